// File: rtl/pdemap_llr.sv
// Purpose: soft demapper, BPSK/QPSK/16QAM symbol -> 1/2/4 scaled, saturated max-log LLRs.
// Latency: first LLR is valid the cycle after symbol acceptance, then one LLR per cycle.
// Backpressure: LLR stream holds on !do_rdy; di_rdy only in IDLE or on the last LLR handshake.
//
// Ports:
//   clk, rst                      clock, async active-high reset
//   di_re/di_im/di_mode           equalised symbol and modulation (00 BPSK, 01 QPSK, 10 16QAM, 11 reserved)
//   di_vld/di_rdy                 symbol handshake
//   di_isig2/di_isig2_vld         inverse noise variance load
//   do_llr/do_last/do_vld/do_rdy  LLR stream, do_last marks the final LLR of a symbol
//   mode_err                      one-cycle pulse after a reserved-mode symbol is accepted
module pdemap_llr #(
    parameter int DW    = 12,
    parameter int IW    = 12,
    parameter int LW    = 8,
    parameter int SHIFT = 10,
    parameter int THR16 = 648
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic signed [DW-1:0] di_re,
    input  logic signed [DW-1:0] di_im,
    input  logic [1:0]           di_mode,
    input  logic                 di_vld,
    output logic                 di_rdy,
    input  logic [IW-1:0]        di_isig2,
    input  logic                 di_isig2_vld,
    output logic signed [LW-1:0] do_llr,
    output logic                 do_vld,
    output logic                 do_last,
    input  logic                 do_rdy,
    output logic                 mode_err
);

    localparam int MW = DW + 1;        // metric width
    localparam int PW = DW + IW + 2;   // product width

    localparam logic signed [MW-1:0] THR  = MW'(THR16);
    localparam logic signed [PW-1:0] LMAX = PW'((2 ** (LW - 1)) - 1);
    localparam logic signed [PW-1:0] LMIN = -LMAX;

    typedef enum logic {IDLE, EMIT} state_t;

    state_t               state, state_nxt;
    logic signed [MW-1:0] mbuf [4];
    logic [IW-1:0]        isig, isig_sh;
    logic [1:0]           beat, last_beat;
    logic                 accept, fire, is_last;
    logic signed [MW-1:0] re_x, im_x, re_abs, im_abs;
    logic signed [PW-1:0] m_ext, s_ext, prod, q;
    logic signed [LW-1:0] llr_sat;

    assign accept  = di_vld & di_rdy;
    assign fire    = do_vld & do_rdy;
    assign is_last = (beat == last_beat);

    // Metric formation; |x| of the most negative input still fits in DW+1 bits.
    always_comb begin
        re_x   = MW'(di_re);
        im_x   = MW'(di_im);
        re_abs = re_x[MW-1] ? -re_x : re_x;
        im_abs = im_x[MW-1] ? -im_x : im_x;
    end

    // Single shared multiplier; the shadow scale is unsigned, so zero-extend before signed multiply.
    always_comb begin
        m_ext = PW'(mbuf[beat]);
        s_ext = PW'($signed({1'b0, isig_sh}));
        prod  = m_ext * s_ext;
        q     = prod >>> SHIFT;
        if (q > LMAX)
            llr_sat = LW'(LMAX);
        else if (q < LMIN)
            llr_sat = LW'(LMIN);
        else
            llr_sat = LW'(q);
    end

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = EMIT;
            EMIT: if (fire && is_last) state_nxt = accept ? EMIT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        do_vld  = (state == EMIT);
        do_last = do_vld & is_last;
        do_llr  = do_vld ? llr_sat : '0;
        di_rdy  = (state == IDLE) | (do_vld & do_rdy & is_last);
    end

    // Symbol buffer, scale registers and beat counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++)
                mbuf[i] <= '0;
            isig      <= '0;
            isig_sh   <= '0;
            beat      <= '0;
            last_beat <= '0;
            mode_err  <= 1'b0;
        end else begin
            mode_err <= accept && (di_mode == 2'b11);
            if (di_isig2_vld)
                isig <= di_isig2;
            if (accept) begin
                // A scale load coinciding with acceptance applies to this symbol.
                isig_sh <= di_isig2_vld ? di_isig2 : isig;
                beat    <= '0;
                case (di_mode)
                    2'b00: begin
                        mbuf[0]   <= re_x;
                        last_beat <= 2'd0;
                    end
                    2'b10: begin
                        mbuf[0]   <= re_x;
                        mbuf[1]   <= THR - re_abs;
                        mbuf[2]   <= im_x;
                        mbuf[3]   <= THR - im_abs;
                        last_beat <= 2'd3;
                    end
                    default: begin  // QPSK and reserved mode
                        mbuf[0]   <= re_x;
                        mbuf[1]   <= im_x;
                        last_beat <= 2'd1;
                    end
                endcase
            end else if (fire && !is_last) begin
                beat <= beat + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_pdemap_llr.sv
module tb_pdemap_llr;

    logic              clk = 1'b0;
    logic              rst;
    logic signed [11:0] di_re, di_im;
    logic [1:0]        di_mode;
    logic              di_vld, di_rdy;
    logic [11:0]       di_isig2;
    logic              di_isig2_vld;
    logic signed [7:0] do_llr;
    logic              do_vld, do_last, do_rdy, mode_err;

    pdemap_llr dut (
        .clk          (clk),
        .rst          (rst),
        .di_re        (di_re),
        .di_im        (di_im),
        .di_mode      (di_mode),
        .di_vld       (di_vld),
        .di_rdy       (di_rdy),
        .di_isig2     (di_isig2),
        .di_isig2_vld (di_isig2_vld),
        .do_llr       (do_llr),
        .do_vld       (do_vld),
        .do_last      (do_last),
        .do_rdy       (do_rdy),
        .mode_err     (mode_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int n_merr = 0;
    bit rdy_pat_en = 0;
    int pidx = 0;
    bit rdy_pat [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    int got_llr[$], got_last[$], got_cyc[$];
    int exp_llr[$], exp_last[$];

    bit stall_prev = 0;
    int prev_llr = 0, prev_last = 0;

    task automatic chk(input string tag, input int obs, input int expv);
        n_cmp++;
        if (obs != expv) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    always @(posedge clk) cyc++;

    // Downstream ready driver
    always @(posedge clk) begin
        #1;
        do_rdy = rdy_pat_en ? rdy_pat[pidx] : 1'b1;
        pidx   = (pidx + 1) % 5;
    end

    // Output monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (mode_err) n_merr++;
        if (!rst) begin
            if (stall_prev) begin
                chk("stall_vld", int'(do_vld), 1);
                chk("stall_llr", int'(do_llr), prev_llr);
                chk("stall_last", int'(do_last), prev_last);
            end
            if (do_vld && !do_rdy) begin
                chk("stall_rdy", int'(di_rdy), 0);
                stall_prev = 1;
                prev_llr   = int'(do_llr);
                prev_last  = int'(do_last);
            end else begin
                stall_prev = 0;
            end
            if (do_vld && do_rdy) begin
                got_llr.push_back(int'(do_llr));
                got_last.push_back(int'(do_last));
                got_cyc.push_back(cyc);
            end
            if (!do_vld) begin
                chk("idle_llr", int'(do_llr), 0);
                chk("idle_last", int'(do_last), 0);
            end
        end else begin
            stall_prev = 0;
        end
    end

    task automatic exp(input int l, input int last);
        exp_llr.push_back(l);
        exp_last.push_back(last);
    endtask

    task automatic check_out(input string tag);
        chk({tag, "_count"}, got_llr.size(), exp_llr.size());
        for (int i = 0; i < exp_llr.size() && i < got_llr.size(); i++) begin
            chk({tag, "_llr"}, got_llr[i], exp_llr[i]);
            chk({tag, "_last"}, got_last[i], exp_last[i]);
        end
        got_llr.delete(); got_last.delete(); got_cyc.delete();
        exp_llr.delete(); exp_last.delete();
    endtask

    // Called at posedge+1; returns at posedge+1 right after the acceptance edge.
    task automatic send(input int mode, input int re, input int im, input bit ld, input int ldv);
        int n;
        di_mode      = 2'(mode);
        di_re        = 12'(re);
        di_im        = 12'(im);
        di_vld       = 1'b1;
        di_isig2     = 12'(ldv);
        di_isig2_vld = ld;
        n = 0;
        forever begin
            @(negedge clk);
            if (di_rdy) break;
            n++;
            if (n > 100) begin
                chk("send_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk);
        #1;
        acc_cyc      = cyc;
        di_vld       = 1'b0;
        di_isig2_vld = 1'b0;
    endtask

    task automatic load_isig(input int v);
        di_isig2     = 12'(v);
        di_isig2_vld = 1'b1;
        @(posedge clk);
        #1;
        di_isig2_vld = 1'b0;
    endtask

    task automatic drain();
        repeat (12) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        di_re = '0; di_im = '0; di_mode = '0; di_vld = 1'b0;
        di_isig2 = '0; di_isig2_vld = 1'b0; do_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_vld", int'(do_vld), 0);
        chk("rst_last", int'(do_last), 0);
        chk("rst_llr", int'(do_llr), 0);
        chk("rst_merr", int'(mode_err), 0);
        chk("rst_rdy", int'(di_rdy), 1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Unprogrammed scale: all zero
        send(1, 512, -300, 0, 0);
        drain();
        exp(0, 0); exp(0, 1);
        check_out("unprog");

        // QPSK scaling and first-LLR latency
        load_isig(64);
        send(1, 512, -300, 0, 0);
        drain();
        if (got_cyc.size() > 0) chk("latency", got_cyc[0], acc_cyc);
        exp(32, 0); exp(-19, 1);
        check_out("qpsk");

        // 16QAM
        send(2, -900, 100, 0, 0);
        drain();
        exp(-57, 0); exp(-16, 0); exp(6, 0); exp(34, 1);
        check_out("qam16");

        // Saturation, both signs
        load_isig(4095);
        send(0, -2048, 0, 0, 0);
        send(0, 2047, 0, 0, 0);
        drain();
        exp(-127, 1); exp(127, 1);
        check_out("sat");

        // Back-to-back streaming with do_rdy high
        load_isig(64);
        send(1, 512, -300, 0, 0);
        send(1, 100, -100, 0, 0);
        send(1, -512, 300, 0, 0);
        drain();
        for (int i = 1; i < 6 && i < got_cyc.size(); i++)
            chk("stream_cyc", got_cyc[i] - got_cyc[0], i);
        exp(32, 0); exp(-19, 1); exp(6, 0); exp(-7, 1); exp(-32, 0); exp(18, 1);
        check_out("stream");

        // Same stream under a stalling do_rdy pattern
        rdy_pat_en = 1;
        send(1, 512, -300, 0, 0);
        send(1, 100, -100, 0, 0);
        send(1, -512, 300, 0, 0);
        drain();
        rdy_pat_en = 0;
        exp(32, 0); exp(-19, 1); exp(6, 0); exp(-7, 1); exp(-32, 0); exp(18, 1);
        check_out("bp");

        // Scale load coinciding with acceptance
        send(1, 512, -300, 1, 128);
        drain();
        exp(64, 0); exp(-38, 1);
        check_out("isig_acc");

        // Scale load mid-symbol keeps the old scale for that symbol
        send(2, -900, 100, 0, 0);
        load_isig(64);
        drain();
        exp(-113, 0); exp(-32, 0); exp(12, 0); exp(68, 1);
        check_out("isig_mid");

        // Reserved mode behaves as QPSK with one error pulse
        chk("no_merr", n_merr, 0);
        send(3, 512, -300, 0, 0);
        chk("merr_pulse", int'(mode_err), 1);
        drain();
        chk("merr_count", n_merr, 1);
        exp(32, 0); exp(-19, 1);
        check_out("mode11");

        // Reset on beat 2 of a 16QAM symbol
        send(2, -900, 100, 0, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_rst_vld", int'(do_vld), 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_vld", int'(do_vld), 0);
        chk("mid_rst_rdy", int'(di_rdy), 1);
        chk("mid_rst_last", int'(do_last), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        drain();
        exp(-57, 0); exp(-16, 0);
        check_out("rst_mid");

        // Scale is cleared by reset
        send(1, 512, -300, 0, 0);
        drain();
        exp(0, 0); exp(0, 1);
        check_out("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
